// File: rtl/imm_extend_pipe_pkg.sv
// Shared mode encodings and default widths for the immediate extension stage.
// Mode 5 zero-extension is enabled by defining IMM_EXTEND_ZEXT_EN.
package imm_extend_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_MODE_SIGNED        = 3'd0,
    IMM_MODE_SHAMT         = 3'd1,
    IMM_MODE_OFFSET        = 3'd2,
    IMM_MODE_OFFSET_SCALED = 3'd3,
    IMM_MODE_UPPER         = 3'd4,
    IMM_MODE_ZEXT          = 3'd5
  } imm_mode_e;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_FIELD_WIDTH  = 20;
  localparam int DEF_IMM_WIDTH    = 12;
  localparam int DEF_SHAMT_WIDTH  = 5;
  localparam int DEF_OFFSET_WIDTH = 12;
  localparam int DEF_OFFSET_SHIFT = 2;
  localparam int DEF_UPPER_WIDTH  = 20;
  localparam int DEF_TAG_WIDTH    = 5;

  function automatic logic mode_supported(logic [2:0] mode);
    logic ok;
    ok = (mode <= IMM_MODE_UPPER);
`ifdef IMM_EXTEND_ZEXT_EN
    ok = ok || (mode == IMM_MODE_ZEXT);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational field/mode -> extended value unit; no state.
// Mode 5 zero-extension exists only when IMM_EXTEND_ZEXT_EN is defined.
module imm_extend_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FIELD_WIDTH  = DEF_FIELD_WIDTH,
  parameter int IMM_WIDTH    = DEF_IMM_WIDTH,
  parameter int SHAMT_WIDTH  = DEF_SHAMT_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int OFFSET_SHIFT = DEF_OFFSET_SHIFT,
  parameter int UPPER_WIDTH  = DEF_UPPER_WIDTH
) (
  input  logic [FIELD_WIDTH-1:0] field,
  input  logic [2:0]             mode,
  output logic [DATA_WIDTH-1:0]  value,
  output logic                   mode_err
);

  if (IMM_WIDTH > FIELD_WIDTH || SHAMT_WIDTH > FIELD_WIDTH ||
      OFFSET_WIDTH > FIELD_WIDTH || UPPER_WIDTH > FIELD_WIDTH ||
      IMM_WIDTH > DATA_WIDTH || SHAMT_WIDTH > DATA_WIDTH ||
      OFFSET_WIDTH > DATA_WIDTH || UPPER_WIDTH > DATA_WIDTH) begin : g_bad_widths
    $error("imm_extend_core: per-mode widths must fit FIELD_WIDTH and DATA_WIDTH");
  end

  logic signed [IMM_WIDTH-1:0]    imm_s;
  logic signed [OFFSET_WIDTH-1:0] off_s;
  logic signed [DATA_WIDTH-1:0]   imm_sx;
  logic signed [DATA_WIDTH-1:0]   off_sx;
  logic signed [DATA_WIDTH-1:0]   off_scaled;
  logic [DATA_WIDTH-1:0]          shamt_zx;
  logic [DATA_WIDTH-1:0]          upper_v;
  logic                           unused_field;

  assign imm_s      = field[IMM_WIDTH-1:0];
  assign off_s      = field[OFFSET_WIDTH-1:0];
  assign imm_sx     = DATA_WIDTH'(imm_s);
  assign off_sx     = DATA_WIDTH'(off_s);
  // Bits shifted past the top of the word are simply lost.
  assign off_scaled = off_sx <<< OFFSET_SHIFT;
  assign shamt_zx   = DATA_WIDTH'(field[SHAMT_WIDTH-1:0]);
  assign upper_v    = DATA_WIDTH'(field[UPPER_WIDTH-1:0]) << (DATA_WIDTH - UPPER_WIDTH);

  // Field bits above the widest mode are ignored by design.
  assign unused_field = ^field;

`ifdef IMM_EXTEND_ZEXT_EN
  logic [DATA_WIDTH-1:0] zext_v;
  assign zext_v = DATA_WIDTH'(field[IMM_WIDTH-1:0]);
`endif

  always_comb begin
    value    = '0;
    mode_err = 1'b0;
    case (mode)
      IMM_MODE_SIGNED:        value = imm_sx;
      IMM_MODE_SHAMT:         value = shamt_zx;
      IMM_MODE_OFFSET:        value = off_sx;
      IMM_MODE_OFFSET_SCALED: value = off_scaled;
      IMM_MODE_UPPER:         value = upper_v;
`ifdef IMM_EXTEND_ZEXT_EN
      IMM_MODE_ZEXT:          value = zext_v;
`endif
      default:                mode_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extension stage with a 2-entry skid buffer and flush.
// Optional mode 5 zero-extension is enabled by defining IMM_EXTEND_ZEXT_EN.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FIELD_WIDTH  = DEF_FIELD_WIDTH,
  parameter int IMM_WIDTH    = DEF_IMM_WIDTH,
  parameter int SHAMT_WIDTH  = DEF_SHAMT_WIDTH,
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int OFFSET_SHIFT = DEF_OFFSET_SHIFT,
  parameter int UPPER_WIDTH  = DEF_UPPER_WIDTH,
  parameter int TAG_WIDTH    = DEF_TAG_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [FIELD_WIDTH-1:0] field_i,
  input  logic [2:0]             mode_i,
  input  logic [TAG_WIDTH-1:0]   tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  extended_o,
  output logic [TAG_WIDTH-1:0]   tag_o,
  output logic                   mode_err_o
);

  logic [DATA_WIDTH-1:0] ext_p0;
  logic                  err_p0;
  logic                  accept_p0;

  logic                  main_vld_p1;
  logic [DATA_WIDTH-1:0] main_ext_p1;
  logic [TAG_WIDTH-1:0]  main_tag_p1;
  logic                  main_err_p1;

  logic                  skid_vld_p1;
  logic [DATA_WIDTH-1:0] skid_ext_p1;
  logic [TAG_WIDTH-1:0]  skid_tag_p1;
  logic                  skid_err_p1;

  imm_extend_core #(
    .DATA_WIDTH   (DATA_WIDTH),
    .FIELD_WIDTH  (FIELD_WIDTH),
    .IMM_WIDTH    (IMM_WIDTH),
    .SHAMT_WIDTH  (SHAMT_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH),
    .OFFSET_SHIFT (OFFSET_SHIFT),
    .UPPER_WIDTH  (UPPER_WIDTH)
  ) u_core (
    .field    (field_i),
    .mode     (mode_i),
    .value    (ext_p0),
    .mode_err (err_p0)
  );

  // Ready depends only on registered state, so a stalled consumer never
  // reaches back to decode combinationally.
  assign in_ready_o = !skid_vld_p1 && !rst_i;
  assign accept_p0  = in_valid_i && in_ready_o && !flush_i;

  // p0 -> p1: main register feeds the outputs, skid absorbs one extra beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_vld_p1 <= 1'b0;
      main_ext_p1 <= '0;
      main_tag_p1 <= '0;
      main_err_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (flush_i) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!main_vld_p1 || out_ready_i) begin
      if (skid_vld_p1) begin
        main_vld_p1 <= 1'b1;
        main_ext_p1 <= skid_ext_p1;
        main_tag_p1 <= skid_tag_p1;
        main_err_p1 <= skid_err_p1;
        skid_vld_p1 <= 1'b0;
      end else begin
        main_vld_p1 <= accept_p0;
        if (accept_p0) begin
          main_ext_p1 <= ext_p0;
          main_tag_p1 <= tag_i;
          main_err_p1 <= err_p0;
        end
      end
    end else if (accept_p0) begin
      skid_vld_p1 <= 1'b1;
      skid_ext_p1 <= ext_p0;
      skid_tag_p1 <= tag_i;
      skid_err_p1 <= err_p0;
    end
  end

  assign out_valid_o = main_vld_p1;
  assign extended_o  = main_ext_p1;
  assign tag_o       = main_tag_p1;
  assign mode_err_o  = main_err_p1;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed modes, backpressure, flush, reset.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [19:0] field_i;
  logic [2:0]  mode_i;
  logic [4:0]  tag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] extended_o;
  logic [4:0]  tag_o;
  logic        mode_err_o;

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .field_i     (field_i),
    .mode_i      (mode_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .extended_o  (extended_o),
    .tag_o       (tag_o),
    .mode_err_o  (mode_err_o)
  );

  typedef struct packed {
    logic [31:0] ext;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
  endtask

  function automatic exp_t model(input logic [19:0] f, input logic [2:0] m, input logic [4:0] t);
    exp_t e;
    e.ext = 32'd0;
    e.tag = t;
    e.err = 1'b0;
    case (m)
      3'd0, 3'd2: e.ext = {{20{f[11]}}, f[11:0]};
      3'd1:       e.ext = {27'd0, f[4:0]};
      3'd3:       e.ext = {{18{f[11]}}, f[11:0], 2'b00};
      3'd4:       e.ext = {f, 12'd0};
`ifdef IMM_EXTEND_ZEXT_EN
      3'd5:       e.ext = {20'd0, f[11:0]};
`endif
      default:    e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor: inputs only change at posedge+1, so the negedge sees what the next edge will act on.
  always @(negedge clk) begin
    exp_t e;
    if (rst_i || flush_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_ext", 64'(extended_o), 64'(e.ext));
          chk("sb_tag", 64'(tag_o), 64'(e.tag));
          chk("sb_err", 64'(mode_err_o), 64'(e.err));
        end
      end
      if (in_valid_i && in_ready_o) sb.push_back(model(field_i, mode_i, tag_i));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] f, input logic [2:0] m, input logic [4:0] t);
    logic acc;
    int   n;
    field_i    = f;
    mode_i     = m;
    tag_i      = t;
    in_valid_i = 1'b1;
    acc        = 1'b0;
    n          = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready_o;
      step();
      n++;
    end
    in_valid_i = 1'b0;
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n;
    out_ready_i = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid_o) && n < 30) begin
      step();
      n++;
    end
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_out_vld", 64'(out_valid_o), 64'd0);
  endtask

  logic [19:0] vf[9];
  logic [2:0]  vm[9];
  logic [31:0] vx[9];
  logic        ve[9];

  initial begin
    vf = '{20'h00800, 20'hFFFFF, 20'h007FF, 20'h00FFF, 20'hABCDE, 20'h12345, 20'h00800, 20'h0FFFF, 20'h80800};
    vm = '{3'd0,      3'd1,      3'd2,      3'd3,      3'd4,      3'd6,      3'd5,      3'd7,      3'd2};
    vx = '{32'hFFFFF800, 32'h0000001F, 32'h000007FF, 32'hFFFFFFFC, 32'hABCDE000,
           32'h0, 32'h0, 32'h0, 32'hFFFFF800};
    ve = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef IMM_EXTEND_ZEXT_EN
    vx[6] = 32'h00000800;
    ve[6] = 1'b0;
`endif

    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    field_i = '0; mode_i = '0; tag_i = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_out_vld", 64'(out_valid_o), 64'd0);
    chk("rst_ext", 64'(extended_o), 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    chk("rst_err", 64'(mode_err_o), 64'd0);
    step();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 64'(in_ready_o), 64'd1);
    step();

    // Directed modes, one beat at a time into an empty stage
    out_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(vf[i], vm[i], 5'(i + 1));
      @(negedge clk);
      chk("lat_vld", 64'(out_valid_o), 64'd1);
      chk($sformatf("dir_ext_m%0d", vm[i]), 64'(extended_o), 64'(vx[i]));
      chk($sformatf("dir_err_m%0d", vm[i]), 64'(mode_err_o), 64'(ve[i]));
      step();
    end
    drain();

    // Backpressure: consumer stalls for three edges while tags 1..6 stream in
    out_ready_i = 1'b0;
    send(20'($urandom_range(0, 20'hFFFFF)), 3'd0, 5'd1);
    send(20'($urandom_range(0, 20'hFFFFF)), 3'd3, 5'd2);
    field_i = 20'h00123; mode_i = 3'd1; tag_i = 5'd3; in_valid_i = 1'b1;
    @(negedge clk);
    chk("bp_rdy_low", 64'(in_ready_o), 64'd0);
    chk("bp_tag_hold", 64'(tag_o), 64'd1);
    step();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_tag_stable", 64'(tag_o), 64'd1);
    chk("bp_rdy_still_low", 64'(in_ready_o), 64'd0);
    step();
    @(negedge clk);
    chk("bp_rdy_rise", 64'(in_ready_o), 64'd1);
    chk("bp_tag_next", 64'(tag_o), 64'd2);
    step();
    for (int t = 3; t <= 6; t++)
      send(20'($urandom_range(0, 20'hFFFFF)), 3'(t % 5), 5'(t));
    drain();

    // Flush with both entries full and a beat arriving
    out_ready_i = 1'b0;
    send(20'h00555, 3'd0, 5'd10);
    send(20'h00AAA, 3'd2, 5'd11);
    field_i = 20'h00777; mode_i = 3'd4; tag_i = 5'd12; in_valid_i = 1'b1;
    flush_i = 1'b1; out_ready_i = 1'b1;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    chk("fl_out_vld", 64'(out_valid_o), 64'd0);
    chk("fl_in_ready", 64'(in_ready_o), 64'd1);
    step(); step(); step();
    send(20'h00FFF, 3'd3, 5'd13);
    drain();

    // Reset in the middle of a stall with a full skid
    out_ready_i = 1'b0;
    send(20'h00800, 3'd0, 5'd20);
    send(20'h12345, 3'd6, 5'd21);
    rst_i = 1'b1;
    field_i = 20'h00001; mode_i = 3'd1; tag_i = 5'd22; in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    @(negedge clk);
    chk("mrst_out_vld", 64'(out_valid_o), 64'd0);
    chk("mrst_ext", 64'(extended_o), 64'd0);
    chk("mrst_tag", 64'(tag_o), 64'd0);
    chk("mrst_err", 64'(mode_err_o), 64'd0);
    chk("mrst_in_ready", 64'(in_ready_o), 64'd0);
    step();
    rst_i = 1'b0; out_ready_i = 1'b1;
    field_i = 20'hABCDE; mode_i = 3'd4; tag_i = 5'd23; in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_vld", 64'(out_valid_o), 64'd1);
    chk("post_rst_tag", 64'(tag_o), 64'd23);
    chk("post_rst_ext", 64'(extended_o), 64'hABCDE000);
    step();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate extension stage for the decode→execute boundary. It accepts one raw instruction field per beat, expands it to DATA_WIDTH in one of several modes (signed, zero-extended shift amount, signed offset, scaled branch offset, upper immediate), and forwards it with a sideband tag. It uses a valid/ready handshake with a 2-entry skid buffer, so decode stalls never create a combinational ready path. A flush drops in-flight beats on branch redirect.

## Interface
Parameters:
- DATA_WIDTH, 32, output word width
- FIELD_WIDTH, 20, raw field input width; must be ≥ every width below
- IMM_WIDTH, 12, signed immediate width (mode 0, mode 5)
- SHAMT_WIDTH, 5, shift-amount width (mode 1)
- OFFSET_WIDTH, 12, signed offset width (modes 2, 3)
- OFFSET_SHIFT, 2, left shift for scaled offset (mode 3)
- UPPER_WIDTH, 20, upper-immediate width (mode 4)
- TAG_WIDTH, 5, sideband tag width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  drop all held and incoming beats
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  stage can accept
- field_i  in  FIELD_WIDTH  raw field, LSB-aligned
- mode_i  in  3  extension mode
- tag_i  in  TAG_WIDTH  sideband, passed through unchanged
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  consumer accepts
- extended_o  out  DATA_WIDTH  extended value
- tag_o  out  TAG_WIDTH  tag of the output beat
- mode_err_o  out  1  output beat came from an unsupported mode

## Operation
- Mode map (the field's low bits are used; upper bits are ignored):
  - 0: sign-extend field[IMM_WIDTH-1:0]
  - 1: zero-extend field[SHAMT_WIDTH-1:0]
  - 2: sign-extend field[OFFSET_WIDTH-1:0]
  - 3: sign-extend field[OFFSET_WIDTH-1:0], then shift left by OFFSET_SHIFT (bits shifted past DATA_WIDTH are discarded)
  - 4: field[UPPER_WIDTH-1:0] placed at the MSBs, low DATA_WIDTH-UPPER_WIDTH bits zero
  - 5: zero-extend field[IMM_WIDTH-1:0]; available only with the macro, see Configuration
  - 6, 7, or 5 without the macro: value 0, mode_err=1
- Extension is computed combinationally on input and captured with its tag and mode_err.
- Storage: main register (drives outputs) plus one skid register.
  - in_ready_o = !skid_valid && !rst_i. The skid register is filled only when the main register is held (out_valid_o && !out_ready_i) and a beat is accepted.
  - When the main register drains and the skid register is valid, the skid entry moves to main in the same cycle. Order is strictly FIFO.
- Accept = in_valid_i && in_ready_o && !flush_i.
- flush_i: at the next edge both entries are invalid. A beat presented in the flush cycle is dropped. flush takes priority over accept and over an output handshake in the same cycle.

## Timing
- Latency: 1 cycle from accept to out_valid_o when the stage is empty.
- Throughput: 1 beat/cycle while out_ready_i=1.
- A consumer stall of N cycles absorbs at most 2 beats. in_ready_o falls the cycle after the skid register fills. in_ready_o rises the cycle after the skid entry moves to main.
- Reset (synchronous, any cycle including mid-transfer): out_valid_o=0, extended_o=0, tag_o=0, mode_err_o=0, skid empty. in_ready_o=0 during the reset cycle and 1 in the first cycle after.
- Data outputs stay stable while out_valid_o && !out_ready_i.
- Parameter rule: every per-mode width ≤ FIELD_WIDTH and ≤ DATA_WIDTH, and UPPER_WIDTH ≤ DATA_WIDTH; otherwise elaboration fails.

## Configuration
- IMM_EXTEND_ZEXT_EN defined: mode 5 gives zero-extended IMM_WIDTH immediates (logical ops), with mode_err=0.
- IMM_EXTEND_ZEXT_EN undefined: mode 5 behaves like modes 6/7 (value 0, mode_err=1), and the zero-extend logic is absent.

## Structure
- Shared package: mode encodings (IMM_MODE_SIGNED, IMM_MODE_SHAMT, IMM_MODE_OFFSET, IMM_MODE_OFFSET_SCALED, IMM_MODE_UPPER, IMM_MODE_ZEXT) and default widths.
- One sub-module: imm_extend_core, a purely combinational field/mode → value/mode_err unit. The top level holds the skid buffer and handshake.

## Test plan
- Defaults, modes 0/1/2: field 0x00800 mode 0 → 0xFFFFF800; field 0xFFFFF mode 1 → 0x0000001F; field 0x007FF mode 2 → 0x000007FF. Each output appears 1 cycle after accept.
- Mode 3 field 0x00FFF → 0xFFFFFFFC. Mode 4 field 0xABCDE → 0xABCDE000. Mode 6 → 0, mode_err_o=1.
- Backpressure: stream tags 1..6 with out_ready_i low for 3 cycles. in_ready_o drops after 2 held beats. Output tag order is 1..6 with no loss or duplication.
- Flush with both entries full plus an incoming beat: next cycle out_valid_o=0 and in_ready_o=1. No flushed tag appears.
- Reset asserted mid-stall with a full skid: all outputs 0 the next cycle. Normal acceptance resumes the cycle after reset deasserts.
- Macro: mode 5 field 0x00800 → 0x00000800 with IMM_EXTEND_ZEXT_EN defined; → 0 with mode_err_o=1 without it.
